// File: rtl/ysyx_22050039_seq_ctrl.sv
// ysyx_22050039_seq_ctrl: multi-cycle FREQ/FWAIT/DEC/EXEC/WB sequencer with a sticky halt.
// Performance counters (mcycle/minstret) are built only when PERF_CNT_EN is defined.
module ysyx_22050039_seq_ctrl #(
   parameter int unsigned XLEN     = 64,
   parameter int unsigned INST_LEN = 32,
   parameter int unsigned CNT_W    = 64
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   output logic                o_imem_req_valid,
   input  logic                i_imem_req_ready,
   input  logic                i_imem_rsp_valid,
   input  logic [INST_LEN-1:0] i_imem_rsp_inst,
   output logic [INST_LEN-1:0] o_inst,
   input  logic                i_dec_ebreak,
   input  logic                i_dec_illegal,
   output logic                o_exu_start,
   input  logic                i_exu_done,
   output logic                o_rf_wen,
   output logic                o_pc_wen,
   output logic                o_halted,
   output logic [1:0]          o_halt_code,
   output logic [CNT_W-1:0]    o_mcycle,
   output logic [CNT_W-1:0]    o_minstret
);

   typedef enum logic [2:0] {
      StFreq,
      StFwait,
      StDec,
      StExec,
      StWb,
      StHalt
   } state_e;

   localparam logic [1:0] HaltRun     = 2'b00;
   localparam logic [1:0] HaltEbreak  = 2'b01;
   localparam logic [1:0] HaltIllegal = 2'b10;

   // XLEN only matters to the surrounding core; catch an inconsistent build early.
   if (XLEN < INST_LEN) begin : g_xlen_chk
      $error("XLEN must not be narrower than INST_LEN");
   end

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_req_valid;
   logic                r_exu_start;
   logic                r_wb;
   logic                r_halted;
   logic [1:0]          r_halt_code;
   logic [1:0]          w_halt_code_nxt;
   logic [INST_LEN-1:0] r_inst;
   logic                w_inst_load;

   always_comb begin
      w_state_nxt     = r_state;
      w_halt_code_nxt = r_halt_code;
      w_inst_load     = 1'b0;
      unique case (r_state)
         StFreq: begin
            // Handshake uses the registered valid, so the cycle right after reset never fires.
            if (r_req_valid && i_imem_req_ready) begin
               w_state_nxt = StFwait;
            end
         end
         StFwait: begin
            if (i_imem_rsp_valid) begin
               w_inst_load = 1'b1;
               w_state_nxt = StDec;
            end
         end
         StDec: begin
            if (i_dec_illegal) begin
               w_state_nxt     = StHalt;
               w_halt_code_nxt = HaltIllegal;
            end else if (i_dec_ebreak) begin
               w_state_nxt     = StHalt;
               w_halt_code_nxt = HaltEbreak;
            end else begin
               w_state_nxt = StExec;
            end
         end
         StExec: begin
            if (i_exu_done) begin
               w_state_nxt = StWb;
            end
         end
         StWb: begin
            w_state_nxt = StFreq;
         end
         StHalt: begin
            w_state_nxt = StHalt;
         end
         default: begin
            w_state_nxt = StFreq;
         end
      endcase
   end

   // Strobes are registered from the next state so each one is glitch-free and Moore-timed.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= StFreq;
         r_req_valid <= 1'b0;
         r_exu_start <= 1'b0;
         r_wb        <= 1'b0;
         r_halted    <= 1'b0;
         r_halt_code <= HaltRun;
         r_inst      <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_req_valid <= (w_state_nxt == StFreq);
         r_exu_start <= (r_state == StDec) && (w_state_nxt == StExec);
         r_wb        <= (w_state_nxt == StWb);
         r_halted    <= (w_state_nxt == StHalt);
         r_halt_code <= w_halt_code_nxt;
         if (w_inst_load) begin
            r_inst <= i_imem_rsp_inst;
         end
      end
   end

   assign o_imem_req_valid = r_req_valid;
   assign o_exu_start      = r_exu_start;
   assign o_rf_wen         = r_wb;
   assign o_pc_wen         = r_wb;
   assign o_halted         = r_halted;
   assign o_halt_code      = r_halt_code;
   assign o_inst           = r_inst;

`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] r_mcycle;
   logic [CNT_W-1:0] r_minstret;
   logic             w_retire;

   // An ebreak retires in DEC; an illegal instruction never retires.
   assign w_retire = (r_state == StWb) ||
                     ((r_state == StDec) && !i_dec_illegal && i_dec_ebreak);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mcycle   <= '0;
         r_minstret <= '0;
      end else begin
         if (r_state != StHalt) begin
            r_mcycle <= r_mcycle + CNT_W'(1);
         end
         if (w_retire) begin
            r_minstret <= r_minstret + CNT_W'(1);
         end
      end
   end

   assign o_mcycle   = r_mcycle;
   assign o_minstret = r_minstret;
`else
   assign o_mcycle   = '0;
   assign o_minstret = '0;
`endif

endmodule
